// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_REL   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_event_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_REL) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Key-event handshake between the PS/2 receiver (master) and the keyboard-matrix logic (slave).
interface ps2_kbd_rx_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_ack;

    modport master (output key_valid, key_code, key_ext, key_release, input key_ack);
    modport slave  (input key_valid, key_code, key_ext, key_release, output key_ack);
endinterface

// File: rtl/ps2_kbd_fifo.sv
// Synchronous event FIFO, depth 2**FIFO_BITS; overflow drops the incoming word and pulses o_ovf.
module ps2_kbd_fifo #(
    parameter int unsigned FIFO_BITS = 2,
    parameter int unsigned WIDTH     = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_ovf
);
    localparam int unsigned DEPTH = 2 ** FIFO_BITS;
    localparam logic [FIFO_BITS:0] PTR_ONE = 1;

    logic [FIFO_BITS:0] r_wr_ptr, r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               r_ovf;
    logic               w_full, w_empty, w_push, w_pop;

    // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_BITS] != r_rd_ptr[FIFO_BITS]) &&
                     (r_wr_ptr[FIFO_BITS-1:0] == r_rd_ptr[FIFO_BITS-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_ovf <= i_push & w_full & ~w_pop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_BITS-1:0]] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[FIFO_BITS-1:0]];
    assign o_empty = w_empty;
    assign o_ovf   = r_ovf;
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync/filter, frame FSM, E0/F0 prefix decoder, event FIFO.
// Optional frame watchdog enabled by defining PS2_KBD_TIMEOUT_EN.
module ps2_kbd_rx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 16384,
    parameter int unsigned FIFO_BITS  = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ps2_kbd_clk,
    input  logic          ps2_kbd_data,
    ps2_kbd_rx_if.master  kbd_if,
    output logic          frame_err,
    output logic          fifo_ovf
);
    logic [1:0] r_clk_s, r_dat_s;
    logic       r_clk_f, r_fe;
    logic [3:0] r_flt_cnt;
    logic       w_dat;

    rx_state_e  r_state, w_state_nxt;
    logic [7:0] r_shift, r_byte;
    logic [2:0] r_bit_cnt;
    logic       r_par, r_par_ok;
    logic       r_frame_err, r_byte_vld, r_ext, r_rel;
    logic       w_frame_ok, w_frame_bad, w_timeout;

    kbd_event_t w_event, w_head;
    logic       w_push, w_pop, w_empty, w_ovf;

    assign w_dat = r_dat_s[1];

    // Filtered clock follows the synchronised clock after FILTER_LEN differing samples.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_clk_s   <= 2'b11;
            r_dat_s   <= 2'b11;
            r_clk_f   <= 1'b1;
            r_flt_cnt <= '0;
            r_fe      <= 1'b0;
        end else begin
            r_clk_s <= {r_clk_s[0], ps2_kbd_clk};
            r_dat_s <= {r_dat_s[0], ps2_kbd_data};
            r_fe    <= 1'b0;
            if (r_clk_s[1] == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == 4'(FILTER_LEN - 1)) begin
                r_clk_f   <= r_clk_s[1];
                r_flt_cnt <= '0;
                r_fe      <= r_clk_f;
            end else begin
                r_flt_cnt <= r_flt_cnt + 4'd1;
            end
        end
    end

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n || r_state == IDLE || r_fe) r_wd_cnt <= '0;
        else                                     r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end

    assign w_timeout = (r_state != IDLE) && !r_fe && (r_wd_cnt == WD_W'(TIMEOUT - 1));
`else
    // No watchdog in this build; TIMEOUT has no effect.
    assign w_timeout = 1'b0 && (TIMEOUT == 0);
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (r_fe) begin
            unique case (r_state)
                IDLE:    if (!w_dat) w_state_nxt = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_frame_ok  = 1'b0;
        w_frame_bad = w_timeout;
        if (r_fe && r_state == STOP) begin
            if (r_par_ok && w_dat) w_frame_ok  = 1'b1;
            else                   w_frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b1;
            r_par_ok  <= 1'b0;
        end else if (r_fe) begin
            unique case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_par     <= 1'b1;
                end
                DATA: begin
                    r_shift   <= {w_dat, r_shift[7:1]};
                    r_par     <= r_par ^ w_dat;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                PARITY:  r_par_ok <= (w_dat == r_par);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
            r_byte_vld  <= 1'b0;
            r_byte      <= '0;
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_byte_vld  <= w_frame_ok;
            if (w_frame_ok) r_byte <= r_shift;
            if (w_frame_bad) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else if (r_byte_vld) begin
                if (r_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_byte == PS2_REL) begin
                    r_rel <= 1'b1;
                end else if (r_byte != PS2_PAUSE) begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end
            end
        end
    end

    assign w_push  = r_byte_vld && !is_prefix(r_byte);
    assign w_event = '{ext: r_ext, rel: r_rel, code: r_byte};
    assign w_pop   = ~w_empty & kbd_if.key_ack;

    ps2_kbd_fifo #(
        .FIFO_BITS (FIFO_BITS),
        .WIDTH     ($bits(kbd_event_t))
    ) u_fifo (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_event),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_ovf   (w_ovf)
    );

    assign kbd_if.key_valid   = ~w_empty;
    assign kbd_if.key_code    = w_head.code;
    assign kbd_if.key_ext     = w_head.ext;
    assign kbd_if.key_release = w_head.rel;
    assign frame_err          = r_frame_err;
    assign fifo_ovf           = w_ovf;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: randomized PS/2 frames against a byte-level event model.
module tb_ps2_kbd_rx;
    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 16384;
    localparam int unsigned FIFO_BITS  = 2;
    localparam int unsigned DEPTH      = 4;
    localparam int          HP         = 12;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic frame_err, fifo_ovf;

    ps2_kbd_rx_if kbd_if ();

    ps2_kbd_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .FIFO_BITS  (FIFO_BITS)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_kbd_clk  (ps2_clk),
        .ps2_kbd_data (ps2_dat),
        .kbd_if       (kbd_if),
        .frame_err    (frame_err),
        .fifo_ovf     (fifo_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass = 0;
    int n_total = 0;
    int err_cycles = 0;
    int ovf_cycles = 0;

    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) err_cycles++;
        if (fifo_ovf === 1'b1) ovf_cycles++;
    end

    // Reference model: bytes in, key events out, depth-limited queue.
    logic [9:0] exp_q[$];
    bit m_ext = 1'b0;
    bit m_rel = 1'b0;
    int exp_err = 0;
    int exp_ovf = 0;

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 1'b0;
            m_rel = 1'b0;
            exp_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b != 8'hE1) begin
            if (exp_q.size() >= DEPTH) exp_ovf++;
            else exp_q.push_back({m_ext, m_rel, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    function automatic logic [7:0] rand_code();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'hE0 || c == 8'hF0 || c == 8'hE1);
        return c;
    endfunction

    task automatic ps2_bit(input logic v, input int hp);
        ps2_dat = v;
        repeat (hp) @(posedge clk_sys);
        #1 ps2_clk = 1'b0;
        repeat (hp) @(posedge clk_sys);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input int hp);
        logic [10:0] f;
        f = frame_bits(b, flip);
        for (int i = 0; i < 11; i++) ps2_bit(f[i], hp);
        ps2_dat = 1'b1;
        repeat (20) @(posedge clk_sys);
        model_byte(b, !flip);
    endtask

    task automatic drain(input string tag);
        int n;
        logic [9:0] exp_ev, got;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            exp_ev = exp_q.pop_front();
            @(negedge clk_sys);
            got = {kbd_if.key_ext, kbd_if.key_release, kbd_if.key_code};
            n_total++;
            if (kbd_if.key_valid !== 1'b1 || got !== exp_ev)
                $display("FAIL %s event %0d: got valid=%b {ext,rel,code}=%h, want valid=1 %h",
                         tag, i, kbd_if.key_valid, got, exp_ev);
            else n_pass++;
            kbd_if.key_ack = 1'b1;
            @(negedge clk_sys);
            kbd_if.key_ack = 1'b0;
        end
        @(negedge clk_sys);
        n_total++;
        if (kbd_if.key_valid !== 1'b0)
            $display("FAIL %s empty: got key_valid=%b, want 0", tag, kbd_if.key_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if ({kbd_if.key_valid, kbd_if.key_code, kbd_if.key_ext, kbd_if.key_release,
             frame_err, fifo_ovf} !== 13'd0)
            $display("FAIL reset_outputs: got v=%b code=%h e=%b r=%b ferr=%b ovf=%b, want all 0",
                     kbd_if.key_valid, kbd_if.key_code, kbd_if.key_ext, kbd_if.key_release,
                     frame_err, fifo_ovf);
        else n_pass++;
        reset_n = 1'b1;
        repeat (10) @(posedge clk_sys);
        // ack while empty must be ignored
        @(negedge clk_sys);
        kbd_if.key_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        kbd_if.key_ack = 1'b0;
        n_total++;
        if (kbd_if.key_valid !== 1'b0 || ovf_cycles != 0 || err_cycles != 0)
            $display("FAIL empty_ack: got valid=%b ovf=%0d err=%0d, want 0/0/0",
                     kbd_if.key_valid, ovf_cycles, err_cycles);
        else n_pass++;
    endtask

    task automatic test_latency();
        logic [10:0] f;
        int lat;
        f = frame_bits(8'h1C, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i], 101);
        ps2_dat = 1'b1;
        repeat (101) @(posedge clk_sys);
        #1 ps2_clk = 1'b0;
        lat = -1;
        for (int n = 1; n <= 101; n++) begin
            @(posedge clk_sys);
            #1;
            if (lat < 0 && kbd_if.key_valid === 1'b1) lat = n;
        end
        ps2_clk = 1'b1;
        repeat (20) @(posedge clk_sys);
        model_byte(8'h1C, 1'b1);
        // 2 sync + FILTER_LEN filter cycles to the fe, then 2 more to key_valid
        n_total++;
        if (lat != 2 + FILTER_LEN + 2)
            $display("FAIL latency: got %0d cycles after clk fall, want %0d", lat, 4 + FILTER_LEN);
        else n_pass++;
        drain("single_1C");
    endtask

    task automatic test_prefixes();
        send_frame(8'hF0, 1'b0, HP);
        send_frame(8'h1C, 1'b0, HP);
        drain("release_1C");
        send_frame(8'hE0, 1'b0, HP);
        send_frame(8'hF0, 1'b0, HP);
        n_total++;
        if (kbd_if.key_valid !== 1'b0)
            $display("FAIL prefix_no_event: got key_valid=%b, want 0", kbd_if.key_valid);
        else n_pass++;
        send_frame(8'h75, 1'b0, HP);
        drain("ext_rel_75");
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_cycles;
        send_frame(8'hF0, 1'b0, HP);
        send_frame(8'h1C, 1'b1, HP);
        n_total++;
        if (err_cycles - e0 != 1 || kbd_if.key_valid !== 1'b0)
            $display("FAIL parity_err: got err_cycles=%0d valid=%b, want 1 and 0",
                     err_cycles - e0, kbd_if.key_valid);
        else n_pass++;
        send_frame(8'h32, 1'b0, HP);
        drain("after_err_32");
    endtask

    task automatic test_overflow();
        int o0;
        o0 = ovf_cycles;
        for (int i = 0; i < 4; i++) send_frame(rand_code(), 1'b0, HP);
        n_total++;
        if (ovf_cycles != o0)
            $display("FAIL ovf_early: got %0d ovf cycles after 4 pushes, want 0", ovf_cycles - o0);
        else n_pass++;
        send_frame(rand_code(), 1'b0, HP);
        n_total++;
        if (ovf_cycles - o0 != 1 || exp_ovf != 1)
            $display("FAIL ovf_pulse: got %0d ovf cycles, want 1 (model %0d)", ovf_cycles - o0,
                     exp_ovf);
        else n_pass++;
        drain("ovf_order");
    endtask

    task automatic test_glitch_reset();
        logic [10:0] f;
        logic [7:0] c;
        int e0;
        e0 = err_cycles;
        c = rand_code();
        f = frame_bits(c, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(f[i], HP);
        repeat (5) @(posedge clk_sys);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 ps2_clk = 1'b1;
        for (int i = 3; i < 11; i++) ps2_bit(f[i], HP);
        ps2_dat = 1'b1;
        repeat (20) @(posedge clk_sys);
        model_byte(c, 1'b1);
        drain("glitch_frame");

        send_frame(8'hE0, 1'b0, HP);
        f = frame_bits(rand_code(), 1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(f[i], HP);
        ps2_dat = 1'b1;
        @(posedge clk_sys);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
        exp_q.delete();
        repeat (10) @(posedge clk_sys);
        n_total++;
        if (kbd_if.key_valid !== 1'b0 || err_cycles != e0)
            $display("FAIL reset_midframe: got valid=%b err_cycles=%0d, want 0 and 0",
                     kbd_if.key_valid, err_cycles - e0);
        else n_pass++;
        send_frame(rand_code(), 1'b0, HP);
        drain("after_reset");
    endtask

    task automatic test_random();
        int e0, o0, keys;
        bit bad;
        logic [7:0] c;
        for (int r = 0; r < 6; r++) begin
            e0 = err_cycles;
            o0 = ovf_cycles;
            exp_err = 0;
            keys = $urandom_range(1, 3);
            for (int k = 0; k < keys; k++) begin
                if ($urandom_range(0, 1) == 1) send_frame(8'hE0, 1'b0, HP);
                if ($urandom_range(0, 3) == 0) send_frame(8'hE1, 1'b0, HP);
                if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 1'b0, HP);
                c = rand_code();
                bad = ($urandom_range(0, 5) == 0);
                send_frame(c, bad, HP);
            end
            n_total++;
            if (err_cycles - e0 != exp_err || ovf_cycles != o0)
                $display("FAIL random%0d_flags: got err=%0d ovf=%0d, want err=%0d ovf=0",
                         r, err_cycles - e0, ovf_cycles - o0, exp_err);
            else n_pass++;
            drain($sformatf("random%0d", r));
        end
    endtask

`ifdef PS2_KBD_TIMEOUT_EN
    task automatic test_timeout();
        logic [10:0] f;
        int e0;
        e0 = err_cycles;
        f = frame_bits(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(f[i], HP);
        ps2_dat = 1'b1;
        repeat (TIMEOUT + 50) @(posedge clk_sys);
        m_ext = 1'b0;
        m_rel = 1'b0;
        n_total++;
        if (err_cycles - e0 != 1)
            $display("FAIL timeout_err: got %0d err cycles, want 1", err_cycles - e0);
        else n_pass++;
        send_frame(8'h29, 1'b0, HP);
        drain("after_timeout_29");
    endtask
`endif

    initial begin
        kbd_if.key_ack = 1'b0;
        test_reset();
        test_latency();
        test_prefixes();
        test_parity_err();
        test_overflow();
        test_glitch_reset();
        test_random();
`ifdef PS2_KBD_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL sim_time_limit: bench did not complete within 3 ms");
        $fatal(1);
    end
endmodule
